spi_master: RTL and testbench

Byte-oriented SPI mode-0 master that drives `sclk`, `cs` and `mosi` and samples `miso`. It is the initiator end of the lab SPI memory link: it produces the serial clock and chip select that the memory's input conditioners and shift register consume. Multi-byte transactions (address/R-W byte followed by data bytes) are supported by holding `cs` low between bytes.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_tick_gen.sv | 27 ++
 rtl/spi_master.sv | 131 +++++++++++++
 tb/tb_spi_master.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI mode-0 master: state encoding, clock mode and default sizing.
package spi_pkg;

    localparam int DEFAULT_CLKDIV = 8;
    localparam int DEFAULT_WIDTH  = 8;

    // Mode 0: sclk idles low, data is captured on the leading (rising) edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_HIGH  = 3'd2;
    localparam state_t ST_LOW   = 3'd3;
    localparam state_t ST_HOLD  = 3'd4;
    localparam state_t ST_TAIL  = 3'd5;
    localparam state_t ST_GUARD = 3'd6;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer: counts CLKDIV clk cycles per state visit and flags the final one.
module spi_tick_gen #(
    parameter int CLKDIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(CLKDIV - 1);

    logic [CW-1:0] count;

    assign tick = (count == TERMINAL);

    // The tick wraps the counter so back-to-back state visits each get a full CLKDIV cycles.
    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI mode-0 master with chip select held across bytes of a multi-byte transaction.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLKDIV = DEFAULT_CLKDIV,
    parameter int WIDTH  = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             last,
    input  logic [WIDTH-1:0] txData,
    output logic [WIDTH-1:0] rxData,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             cs,
    output logic             mosi,
    input  logic             miso
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] FINAL_BIT = BW'(WIDTH - 1);
    localparam logic CAPTURE_LEADING = (SPI_CPHA == 1'b0);

    state_t           state;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] rx_sh;
    logic [WIDTH-1:0] tx_next;
    logic [WIDTH-1:0] rx_next;
    logic [BW-1:0]    bit_cnt;
    logic             last_r;
    logic             tick;
    logic             tick_clear;

    // The timer only runs while a timed phase is active; waiting states keep it parked at zero.
    assign tick_clear = (state == ST_IDLE) || (state == ST_HOLD);
    assign tx_next    = tx_sh << 1;
    assign rx_next    = (rx_sh << 1) | WIDTH'(miso);

    spi_tick_gen #(
        .CLKDIV(CLKDIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(tick_clear),
        .tick (tick)
    );

    // All pins are registered so sclk, cs and mosi change only on clk edges, glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cs      <= 1'b1;
            sclk    <= SPI_CPOL;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rxData  <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
            last_r  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (start) begin
                        tx_sh   <= txData;
                        last_r  <= last;
                        mosi    <= txData[WIDTH-1];
                        cs      <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP, ST_LOW: begin
                    if (tick) begin
                        sclk  <= ~SPI_CPOL;
                        state <= ST_HIGH;
                        if (CAPTURE_LEADING) begin
                            rx_sh <= rx_next;
                        end
                    end
                end
                ST_HIGH: begin
                    if (tick) begin
                        sclk <= SPI_CPOL;
                        if (bit_cnt == FINAL_BIT) begin
                            rxData  <= rx_sh;
                            done    <= 1'b1;
                            bit_cnt <= '0;
                            if (last_r) begin
                                state <= ST_TAIL;
                            end else begin
                                busy  <= 1'b0;
                                state <= ST_HOLD;
                            end
                        end else begin
                            // Next bit goes out on the falling edge, a full half-period before it is sampled.
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_sh   <= tx_next;
                            mosi    <= tx_next[WIDTH-1];
                            state   <= ST_LOW;
                        end
                    end
                end
                ST_TAIL: begin
                    if (tick) begin
                        cs    <= 1'b1;
                        state <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    if (tick) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    cs    <= 1'b1;
                    sclk  <= SPI_CPOL;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed scenarios plus randomized transfers against a timing model.
module tb_spi_master;

    localparam int C    = 8;
    localparam int W    = 8;
    localparam int SPAN = 2 * W * C;

    localparam int M_LOOP = 0;
    localparam int M_PEER = 1;
    localparam int M_COND = 2;
    localparam int M_RAND = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         last;
    logic [W-1:0] txData;
    logic [W-1:0] rxData;
    logic         busy;
    logic         done;
    logic         sclk;
    logic         cs;
    logic         mosi;
    logic         miso;

    int checks = 0;
    int passes = 0;

    int           miso_mode;
    logic         rand_miso;
    logic         peer_load;
    logic [W-1:0] peer_val;
    logic [W-1:0] peer_d;
    logic [W-1:0] peer_c;
    logic         sclk_p;
    logic [2:0]   sclk_c;

    logic tr_sclk [0:255];
    logic tr_cs   [0:255];
    logic tr_busy [0:255];
    logic tr_done [0:255];
    logic tr_mosi [0:255];

    int           rises;
    int           done_cnt;
    int           done_cyc;
    logic [W-1:0] rx_got;
    logic [W-1:0] exp_rx;
    logic [W-1:0] mosi_rise;

    always #10 clk = ~clk;

    spi_master #(
        .CLKDIV(C),
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .last  (last),
        .txData(txData),
        .rxData(rxData),
        .busy  (busy),
        .done  (done),
        .sclk  (sclk),
        .cs    (cs),
        .mosi  (mosi),
        .miso  (miso)
    );

    // Peer slaves: one shifts right after a falling sclk, the other sees sclk through a 3-stage conditioner.
    always @(posedge clk) begin
        sclk_p <= sclk;
        sclk_c <= {sclk_c[1:0], sclk};
        if (peer_load) begin
            peer_d <= peer_val;
            peer_c <= peer_val;
        end else begin
            if (sclk_p && !sclk) peer_d <= peer_d << 1;
            if (sclk_c[2] && !sclk_c[1]) peer_c <= peer_c << 1;
        end
    end

    always_comb begin
        case (miso_mode)
            M_LOOP:  miso = mosi;
            M_PEER:  miso = peer_d[W-1];
            M_COND:  miso = peer_c[W-1];
            default: miso = rand_miso;
        endcase
    end

    task automatic load_peer(input logic [W-1:0] val);
        @(negedge clk);
        peer_val  = val;
        peer_load = 1'b1;
        @(negedge clk);
        peer_load = 1'b0;
    endtask

    // Issues one start at cycle 0 and records ncyc cycles of pin activity; ign_a/ign_b pulse start while busy.
    task automatic transfer(input logic [W-1:0] tx, input logic lst, input int ncyc,
                            input int ign_a, input int ign_b);
        logic prev;
        logic sampled;
        @(negedge clk);
        start     = 1'b1;
        txData    = tx;
        last      = lst;
        prev      = sclk;
        rises     = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        rx_got    = '0;
        exp_rx    = '0;
        mosi_rise = '0;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            start     = (n == ign_a) || (n == ign_b);
            txData    = W'($urandom);
            last      = 1'($urandom);
            rand_miso = 1'($urandom);
            tr_sclk[n] = sclk;
            tr_cs[n]   = cs;
            tr_busy[n] = busy;
            tr_done[n] = done;
            tr_mosi[n] = mosi;
            if (sclk && !prev) rises++;
            prev = sclk;
            if (done) begin
                done_cnt++;
                done_cyc = n;
                rx_got   = rxData;
            end
            if (n <= SPAN && (n % (2 * C)) == C) begin
                sampled   = (miso_mode == M_RAND) ? rand_miso : miso;
                exp_rx    = {exp_rx[W-2:0], sampled};
                mosi_rise = {mosi_rise[W-2:0], mosi};
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cs !== 1'b1) $display("[TB] FAIL reset cs: got %b want 1", cs); else passes++;
        checks++; if (sclk !== 1'b0) $display("[TB] FAIL reset sclk: got %b want 0", sclk); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset busy: got %b want 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL reset done: got %b want 0", done); else passes++;
        checks++; if (rxData !== 8'h00) $display("[TB] FAIL reset rxData: got %h want 00", rxData); else passes++;
        checks++; if (mosi !== 1'b0) $display("[TB] FAIL reset mosi: got %b want 0", mosi); else passes++;
        reset = 1'b0;
    endtask

    task automatic test_loopback;
        miso_mode = M_LOOP;
        transfer(8'hA5, 1'b1, 150, 0, 0);
        checks++; if (done_cyc !== SPAN + 1) $display("[TB] FAIL loopback done cycle: got %0d want %0d", done_cyc, SPAN + 1); else passes++;
        checks++; if (done_cnt !== 1) $display("[TB] FAIL loopback done count: got %0d want 1", done_cnt); else passes++;
        checks++; if (rx_got !== 8'hA5) $display("[TB] FAIL loopback rxData: got %h want a5", rx_got); else passes++;
        checks++; if (rises !== W) $display("[TB] FAIL loopback sclk rises: got %0d want %0d", rises, W); else passes++;
        checks++; if (tr_cs[1] !== 1'b0) $display("[TB] FAIL loopback cs cycle 1: got %b want 0", tr_cs[1]); else passes++;
        checks++; if (tr_busy[1] !== 1'b1) $display("[TB] FAIL loopback busy cycle 1: got %b want 1", tr_busy[1]); else passes++;
        checks++; if (tr_cs[136] !== 1'b0) $display("[TB] FAIL loopback cs cycle 136: got %b want 0", tr_cs[136]); else passes++;
        checks++; if (tr_cs[137] !== 1'b1) $display("[TB] FAIL loopback cs cycle 137: got %b want 1", tr_cs[137]); else passes++;
        checks++; if (tr_cs[145] !== 1'b1) $display("[TB] FAIL loopback cs cycle 145: got %b want 1", tr_cs[145]); else passes++;
        checks++; if (tr_busy[144] !== 1'b1) $display("[TB] FAIL loopback busy cycle 144: got %b want 1", tr_busy[144]); else passes++;
        checks++; if (tr_busy[145] !== 1'b0) $display("[TB] FAIL loopback busy cycle 145: got %b want 0", tr_busy[145]); else passes++;
    endtask

    task automatic test_shift_peer;
        load_peer(8'h3C);
        miso_mode = M_PEER;
        transfer(8'h81, 1'b1, 150, 0, 0);
        checks++; if (rx_got !== 8'h3C) $display("[TB] FAIL peer rxData: got %h want 3c", rx_got); else passes++;
        checks++; if (mosi_rise !== 8'h81) $display("[TB] FAIL peer mosi bits: got %h want 81", mosi_rise); else passes++;
        checks++; if (done_cyc !== SPAN + 1) $display("[TB] FAIL peer done cycle: got %0d want %0d", done_cyc, SPAN + 1); else passes++;
    endtask

    task automatic test_conditioned_peer;
        load_peer(8'b10101010);
        miso_mode = M_COND;
        transfer(W'($urandom), 1'b1, 150, 0, 0);
        checks++; if (rx_got !== 8'hAA) $display("[TB] FAIL conditioned peer rxData: got %h want aa", rx_got); else passes++;
    endtask

    task automatic test_two_byte;
        int bad;
        int dones;
        miso_mode = M_LOOP;
        transfer(8'h55, 1'b0, SPAN + 3, 0, 0);
        bad = 0;
        for (int n = 1; n <= SPAN + 3; n++) if (tr_cs[n] !== 1'b0) bad++;
        checks++; if (bad !== 0) $display("[TB] FAIL two-byte cs first byte: got %0d high cycles want 0", bad); else passes++;
        checks++; if (done_cyc !== SPAN + 1) $display("[TB] FAIL two-byte first done cycle: got %0d want %0d", done_cyc, SPAN + 1); else passes++;
        checks++; if (rx_got !== 8'h55) $display("[TB] FAIL two-byte first rxData: got %h want 55", rx_got); else passes++;
        checks++; if (tr_busy[SPAN + 1] !== 1'b0) $display("[TB] FAIL two-byte busy at done: got %b want 0", tr_busy[SPAN + 1]); else passes++;
        dones = done_cnt;
        transfer(8'hC3, 1'b1, 150, 0, 0);
        dones += done_cnt;
        bad = 0;
        for (int n = 1; n <= SPAN + C; n++) if (tr_cs[n] !== 1'b0) bad++;
        checks++; if (bad !== 0) $display("[TB] FAIL two-byte cs second byte: got %0d high cycles want 0", bad); else passes++;
        checks++; if (tr_cs[SPAN + C + 1] !== 1'b1) $display("[TB] FAIL two-byte cs release: got %b want 1", tr_cs[SPAN + C + 1]); else passes++;
        checks++; if (rx_got !== 8'hC3) $display("[TB] FAIL two-byte second rxData: got %h want c3", rx_got); else passes++;
        checks++; if (dones !== 2) $display("[TB] FAIL two-byte done pulses: got %0d want 2", dones); else passes++;
    endtask

    task automatic test_ignored_start;
        logic [W-1:0] tx;
        miso_mode = M_LOOP;
        tx = W'($urandom);
        transfer(tx, 1'b1, 150, 5, 40);
        checks++; if (done_cnt !== 1) $display("[TB] FAIL ignored-start done count: got %0d want 1", done_cnt); else passes++;
        checks++; if (done_cyc !== SPAN + 1) $display("[TB] FAIL ignored-start done cycle: got %0d want %0d", done_cyc, SPAN + 1); else passes++;
        checks++; if (mosi_rise !== tx) $display("[TB] FAIL ignored-start mosi bits: got %h want %h", mosi_rise, tx); else passes++;
        checks++; if (rx_got !== tx) $display("[TB] FAIL ignored-start rxData: got %h want %h", rx_got, tx); else passes++;
        checks++; if (tr_busy[145] !== 1'b0) $display("[TB] FAIL ignored-start busy cycle 145: got %b want 0", tr_busy[145]); else passes++;
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] tx;
        miso_mode = M_LOOP;
        transfer(8'hE7, 1'b1, 60, 0, 0);
        checks++; if (tr_sclk[60] !== 1'b1) $display("[TB] FAIL reset-mid in 4th high: got sclk %b want 1", tr_sclk[60]); else passes++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (cs !== 1'b1) $display("[TB] FAIL reset-mid cs: got %b want 1", cs); else passes++;
        checks++; if (sclk !== 1'b0) $display("[TB] FAIL reset-mid sclk: got %b want 0", sclk); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset-mid busy: got %b want 0", busy); else passes++;
        checks++; if (rxData !== 8'h00) $display("[TB] FAIL reset-mid rxData: got %h want 00", rxData); else passes++;
        checks++; if (mosi !== 1'b0) $display("[TB] FAIL reset-mid mosi: got %b want 0", mosi); else passes++;
        tx = W'($urandom) | 8'h01;
        transfer(tx, 1'b1, 150, 0, 0);
        checks++; if (rx_got !== tx) $display("[TB] FAIL reset-mid restart rxData: got %h want %h", rx_got, tx); else passes++;
        checks++; if (done_cyc !== SPAN + 1) $display("[TB] FAIL reset-mid restart done cycle: got %0d want %0d", done_cyc, SPAN + 1); else passes++;
    endtask

    // Random bytes, random last flag and random or looped miso, checked cycle by cycle against the timing rules.
    task automatic test_random;
        logic [W-1:0] tx;
        logic         lst;
        int           ncyc;
        logic         e_sclk, e_cs, e_busy, e_done, e_mosi;
        int           bad_sclk, bad_cs, bad_busy, bad_done, bad_mosi;
        for (int it = 0; it < 6; it++) begin
            tx        = W'($urandom);
            lst       = (it == 5) ? 1'b1 : 1'($urandom);
            miso_mode = ($urandom_range(0, 1) == 0) ? M_RAND : M_LOOP;
            ncyc      = lst ? SPAN + 2 * C + 2 : SPAN + 2;
            transfer(tx, lst, ncyc, 0, 0);
            bad_sclk = 0; bad_cs = 0; bad_busy = 0; bad_done = 0; bad_mosi = 0;
            for (int n = 1; n <= ncyc; n++) begin
                e_sclk = (n > C) && (n <= SPAN) && ((((n - 1) / C) % 2) == 1);
                e_cs   = lst && (n > SPAN + C);
                e_busy = lst ? (n <= SPAN + 2 * C) : (n <= SPAN);
                e_done = (n == SPAN + 1);
                e_mosi = (n <= SPAN) ? tx[W - 1 - (n - 1) / (2 * C)] : tx[0];
                if (tr_sclk[n] !== e_sclk) bad_sclk++;
                if (tr_cs[n] !== e_cs) bad_cs++;
                if (tr_busy[n] !== e_busy) bad_busy++;
                if (tr_done[n] !== e_done) bad_done++;
                if (tr_mosi[n] !== e_mosi) bad_mosi++;
            end
            checks++; if (bad_sclk !== 0) $display("[TB] FAIL random[%0d] sclk trace: got %0d bad cycles want 0", it, bad_sclk); else passes++;
            checks++; if (bad_cs !== 0) $display("[TB] FAIL random[%0d] cs trace: got %0d bad cycles want 0", it, bad_cs); else passes++;
            checks++; if (bad_busy !== 0) $display("[TB] FAIL random[%0d] busy trace: got %0d bad cycles want 0", it, bad_busy); else passes++;
            checks++; if (bad_done !== 0) $display("[TB] FAIL random[%0d] done trace: got %0d bad cycles want 0", it, bad_done); else passes++;
            checks++; if (bad_mosi !== 0) $display("[TB] FAIL random[%0d] mosi trace: got %0d bad cycles want 0", it, bad_mosi); else passes++;
            checks++; if (rx_got !== exp_rx) $display("[TB] FAIL random[%0d] rxData: got %h want %h", it, rx_got, exp_rx); else passes++;
            checks++; if (mosi_rise !== tx) $display("[TB] FAIL random[%0d] mosi bits: got %h want %h", it, mosi_rise, tx); else passes++;
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        last      = 1'b0;
        txData    = '0;
        miso_mode = M_LOOP;
        rand_miso = 1'b0;
        peer_load = 1'b0;
        peer_val  = '0;
        test_reset();
        test_loopback();
        test_shift_peer();
        test_conditioned_peer();
        test_two_byte();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
